matriz_multi_param: RTL
=======================

Name: matriz_multi_param

Overview:
Parametrised signed square-matrix multiplier, the successor to the fixed 5x5/8-bit multiplier in the ULA. Computes C = A x B for a runtime-selectable active dimension n (1..DIM), one result row per cycle, with an explicit start/busy/done handshake. Operands are latched at start, and C is published atomically on completion. Sits in the coprocessor ULA beside the other matrix operators.

Parameters:
DIM, 5, maximum matrix dimension (rows = cols); legal range 2..8
W, 8, element width in bits, signed two's complement
ACC_W, 2*W+$clog2(DIM)+1, internal dot-product accumulator width (derived, do not override)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE
size  input  4  active dimension n; 0 or >DIM is treated as DIM
matriz_a  input  DIM*DIM*W  operand A; element (r,c) at bits [(r*DIM+c)*W +: W]
matriz_b  input  DIM*DIM*W  operand B; same layout
matriz_c  output  DIM*DIM*W  result C; same layout, registered
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when matriz_c is updated
overflow  output  1  high with done if any active element exceeded W-bit signed range

Behaviour:
- Reset (reset_n low at a clock edge): state=IDLE; matriz_c=0, busy=0, done=0, overflow=0; internal row counter, operand copies and result buffer cleared. Reset overrides every other input, including mid-operation, and any partial result is discarded.
- States: IDLE -> COMPUTE -> FINISH -> IDLE.
- IDLE: if start=1 at edge E0, latch A, B and the effective n into internal registers. Set row=0, busy=1, done=0, overflow flag clear, and go to COMPUTE. Otherwise hold all outputs; done stays 0.
- COMPUTE: each edge computes row r for c=0..n-1: sum over k=0..n-1 of A[r][k]*B[k][c]. Signed W x W products go into an ACC_W-bit accumulator. Terms with k>=n are excluded. The reduced W-bit value is written to the result buffer. Elements with r>=n or c>=n are written as 0. Rows 0..n-1 are computed at edges E1..En. After row n-1, go to FINISH.
- FINISH (edge En+1): matriz_c <= result buffer (all DIM*DIM elements at once). done=1 for exactly this cycle; busy=0; overflow=sticky OR over the active elements. Return to IDLE.
- Latency: start sampled at E0 -> done and new matriz_c at E(n+1). busy is high from E0 through the cycle ending at E(n+1).
- start while busy=1 is ignored, with no queuing. Changes to matriz_a, matriz_b or size after E0 do not affect the running operation.
- start=1 in the cycle done=1 is ignored (state is FINISH). Back-to-back operations start at the next IDLE cycle.
- matriz_c holds its value between operations. overflow holds its value until the next accepted start clears it.
- Default reduction (macro absent): keep the low W bits of the accumulator (wrap). overflow still reports whether the true sum fell outside [-2^(W-1), 2^(W-1)-1].

Optional Feature:
Macro MATRIZ_MULTI_SATURATE_EN.
- Defined: each active result element is clamped to [-2^(W-1), 2^(W-1)-1] instead of wrapped. overflow behaves as above.
- Undefined: wrap as in the default reduction. overflow still reported. No other differences in timing or ports.

Test Plan:
1. DIM=5, W=8, size=5: A=identity, B=elements 0..24 row-major -> at E6 matriz_c = B, done=1 for one cycle, overflow=0.
2. size=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], garbage in all other elements -> at E3 C=[[19,22],[43,50]], all other elements 0, busy high E0..E2.
3. size=5, A and B all 100 -> each sum is 50000. Without the macro every active element = 80 (0x50), overflow=1. With MATRIZ_MULTI_SATURATE_EN every element = 127, overflow=1.
4. size=3, A all -128, B all 1 -> each sum is -384. Without the macro elements = -128 (0x80). With the macro elements = -128. overflow=1 in both builds. Rows/cols 3..4 = 0.
5. Pulse start again at E2 with different A, and change matriz_a at E2 -> ignored; the result at E(n+1) matches the operands latched at E0; exactly one done pulse.
6. Drive reset_n low at E3 of a size-5 operation -> next edge: busy=0, done=0, matriz_c=0. No done pulse follows. A fresh start then completes normally in 6 cycles.

Source files
------------

// File: rtl/matriz_multi_param.sv
// matriz_multi_param: signed square-matrix multiplier C = A x B that computes one result row per clock.
// With MATRIZ_MULTI_SATURATE_EN defined, result elements are clamped; otherwise they wrap to W bits.
module matriz_multi_param #(
  parameter  int DIM   = 5,
  parameter  int W     = 8,
  localparam int ACC_W = 2*W + $clog2(DIM) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [3:0]           size,
  input  logic [DIM*DIM*W-1:0] matriz_a,
  input  logic [DIM*DIM*W-1:0] matriz_b,
  output logic [DIM*DIM*W-1:0] matriz_c,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2**(W-1) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2**(W-1)));
  localparam logic signed [W-1:0]     EL_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]     EL_MIN  = {1'b1, {(W-1){1'b0}}};

  state_t                 state, state_nx;
  logic [DIM*DIM*W-1:0]   a_q, b_q, buf_q;
  logic [3:0]             n_q, row_q, eff_n;
  logic                   ovf_q;
  logic signed [W-1:0]    row_res [DIM];
  logic                   row_ovf;

  function automatic logic signed [ACC_W-1:0] elem(input logic [DIM*DIM*W-1:0] m,
                                                   input int r, input int c);
    logic signed [W-1:0] e;
    e = m[(r*DIM + c)*W +: W];
    return ACC_W'(e);
  endfunction

  function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic signed [W-1:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef MATRIZ_MULTI_SATURATE_EN
    if (v > ACC_MAX)
      return EL_MAX;
    else if (v < ACC_MIN)
      return EL_MIN;
    else
      return v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  // Out-of-range sizes fall back to the full dimension
  assign eff_n = (size == 4'd0 || int'(size) > DIM) ? 4'(DIM) : size;

  // Row compute: dot products of A row row_q with every column of B
  always_comb begin
    logic signed [ACC_W-1:0] sum;
    row_ovf = 1'b0;
    sum     = '0;
    for (int c = 0; c < DIM; c++) begin
      sum        = '0;
      row_res[c] = '0;
      for (int k = 0; k < DIM; k++)
        if (k < int'(n_q))
          sum = sum + elem(a_q, int'(row_q), k) * elem(b_q, k, c);
      if (int'(row_q) < int'(n_q) && c < int'(n_q)) begin
        row_res[c] = reduce(sum);
        row_ovf    = row_ovf | out_of_range(sum);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COMPUTE;
      COMPUTE: if (row_q == n_q - 4'd1) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result buffer / publish stage
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      buf_q    <= '0;
      n_q      <= '0;
      row_q    <= '0;
      ovf_q    <= 1'b0;
      matriz_c <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= matriz_a;
            b_q      <= matriz_b;
            n_q      <= eff_n;
            row_q    <= '0;
            buf_q    <= '0;
            ovf_q    <= 1'b0;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        COMPUTE: begin
          for (int c = 0; c < DIM; c++)
            buf_q[(int'(row_q)*DIM + c)*W +: W] <= row_res[c];
          ovf_q <= ovf_q | row_ovf;
          row_q <= row_q + 4'd1;
        end
        FINISH: begin
          matriz_c <= buf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          overflow <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule
